// File: rtl/sorter_seq.sv
// sorter_seq: sequential unsigned sorter for N elements of W bits.
// One rank of compare-exchange cells is reused over N odd-even transposition
// phases. Latency is fixed at N cycles from accept to out_valid.
//
// Ports:
//   clk, nrst         clock, asynchronous active-low reset
//   in_valid/in_ready input handshake; in_data packs element k at [k*W +: W]
//   out_valid/out_ready output handshake; out_data sorted, element 0 first
//   desc              (SORTER_DESC_EN only) descending order, sampled at accept
//
// Optional feature macro: SORTER_DESC_EN adds the desc port.
module sorter_seq #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
`ifdef SORTER_DESC_EN
  input  logic           desc,
`endif
  output logic [N*W-1:0] out_data
);

  localparam int unsigned PW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    SORT,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [N*W-1:0] work_q, work_d;
  logic [PW-1:0]  phase_q, phase_d;
  logic           desc_q, desc_d;
  logic [N*W-1:0] stage_c;

  // One compare-exchange rank; pairs start at indices whose parity matches the phase
  always_comb begin
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         swap;
    stage_c = work_q;
    lo      = '0;
    hi      = '0;
    swap    = 1'b0;
    for (int unsigned i = 0; i + 1 < N; i++) begin
      if (1'(i) == phase_q[0]) begin
        lo   = work_q[i*W +: W];
        hi   = work_q[(i+1)*W +: W];
        swap = desc_q ? (lo < hi) : (lo > hi);
        if (swap) begin
          stage_c[i*W +: W]     = hi;
          stage_c[(i+1)*W +: W] = lo;
        end
      end
    end
  end

  // Next-state, working register and handshake logic
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    phase_d  = phase_q;
    desc_d   = desc_q;
    in_ready = 1'b0;
    unique case (state_q)
      IDLE: in_ready = 1'b1;
      SORT: begin
        work_d  = stage_c;
        phase_d = phase_q + PW'(1);
        if (phase_q == PW'(N - 1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d  = IDLE;
          in_ready = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Accept may coincide with the output handshake in DONE
    if (in_valid && in_ready) begin
      work_d  = in_data;
      phase_d = '0;
      state_d = SORT;
`ifdef SORTER_DESC_EN
      desc_d  = desc;
`else
      desc_d  = 1'b0;
`endif
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      work_q  <= '0;
      phase_q <= '0;
      desc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      phase_q <= phase_d;
      desc_q  <= desc_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_data  = work_q;

endmodule

// File: tb/tb_sorter_seq.sv
`timescale 1ns/1ps
module tb_sorter_seq;

  localparam int unsigned NA = 4;
  localparam int unsigned WA = 4;
  localparam int unsigned NB = 8;
  localparam int unsigned WB = 8;
  localparam int          NJOBS = 200;

`ifdef SORTER_DESC_EN
  localparam bit DESC_EN = 1'b1;
`else
  localparam bit DESC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst_a, nrst_b;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_desc;
  logic [15:0] a_in_data, a_out_data;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_desc;
  logic [63:0] b_in_data, b_out_data;

  int tests = 0;
  int fails = 0;
  int b_recv = 0;
  bit b_run = 1'b0;

  logic [15:0] qa[$];
  logic [63:0] qb[$];

  sorter_seq #(.N(NA), .W(WA)) u_a (
    .clk(clk), .nrst(nrst_a),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
`ifdef SORTER_DESC_EN
    .desc(a_desc),
`endif
    .out_data(a_out_data)
  );

  sorter_seq #(.N(NB), .W(WB)) u_b (
    .clk(clk), .nrst(nrst_b),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
`ifdef SORTER_DESC_EN
    .desc(b_desc),
`endif
    .out_data(b_out_data)
  );

  // Reference: unpack, sort the values, repack (element 0 first)
  function automatic logic [63:0] ref_sort(input logic [63:0] d, input int n, input int w,
                                           input bit dsc);
    int unsigned q[$];
    logic [63:0] r;
    logic [63:0] mask;
    r    = '0;
    mask = (64'd1 << w) - 64'd1;
    for (int k = 0; k < n; k++) q.push_back(32'((d >> (k * w)) & mask));
    q.sort();
    if (dsc) q.reverse();
    for (int k = 0; k < n; k++) r = r | (64'(q[k]) << (k * w));
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard for instance A
  always @(negedge clk) begin
    logic [15:0] e;
    if (nrst_a) begin
      if (a_in_valid && a_in_ready)
        qa.push_back(16'(ref_sort(64'(a_in_data), NA, WA, a_desc & DESC_EN)));
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_output", 64'(a_out_data), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = qa.pop_front();
          chk("a_result", 64'(a_out_data), 64'(e));
        end
      end
      if (a_in_ready && a_out_valid && !a_out_ready)
        chk("a_ready_valid_overlap", 64'd1, 64'd0);
    end
  end

  // Scoreboard for instance B, plus hold-stability under backpressure
  logic        b_hold_prev = 1'b0;
  logic [63:0] b_prev = '0;
  always @(negedge clk) begin
    logic [63:0] e;
    if (nrst_b) begin
      if (b_in_valid && b_in_ready)
        qb.push_back(ref_sort(b_in_data, NB, WB, b_desc & DESC_EN));
      if (b_hold_prev) begin
        chk("b_hold_valid", 64'(b_out_valid), 64'd1);
        chk("b_hold_data", b_out_data, b_prev);
      end
      if (b_out_valid && b_out_ready) begin
        b_recv++;
        if (qb.size() == 0) begin
          chk("b_unexpected_output", b_out_data, ~b_out_data);
        end else begin
          e = qb.pop_front();
          chk("b_result", b_out_data, e);
        end
      end
      b_hold_prev = b_out_valid && !b_out_ready;
      b_prev      = b_out_data;
    end
  end

  // Random consumer backpressure for B
  always @(posedge clk) begin
    if (b_run) begin
      #1;
      b_out_ready = ($urandom % 4) != 0;
    end
  end

  // Present a job to A; keep in_valid high with junk data during SORT to prove it is ignored
  task automatic a_start(input logic [15:0] d, input logic ds);
    a_in_data  = d;
    a_desc     = ds;
    a_in_valid = 1'b1;
    chk("a_in_ready_idle", 64'(a_in_ready), 64'd1);
    @(posedge clk); #1;
    a_in_data = ~d;
    a_desc    = ~ds;
  endtask

  // Wait for A's result, checking latency, in_ready low and the data value
  task automatic a_wait(input logic [15:0] exp);
    int lat;
    lat = 0;
    while (!a_out_valid && lat < 20) begin
      chk("a_in_ready_busy", 64'(a_in_ready), 64'd0);
      @(posedge clk); #1;
      lat++;
    end
    a_in_valid = 1'b0;
    chk("a_latency", 64'(lat), 64'(NA));
    chk("a_out_data", 64'(a_out_data), 64'(exp));
  endtask

  task automatic a_hold(input int n, input logic [15:0] exp);
    for (int i = 0; i < n; i++) begin
      chk("a_hold_valid", 64'(a_out_valid), 64'd1);
      chk("a_hold_data", 64'(a_out_data), 64'(exp));
      chk("a_hold_in_ready", 64'(a_in_ready), 64'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic a_take();
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    chk("a_valid_after_take", 64'(a_out_valid), 64'd0);
  endtask

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL global_timeout: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int budget;
    nrst_a = 1'b0; nrst_b = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0; a_desc = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_desc = 1'b0;
    #12;
    chk("reset_out_valid", 64'(a_out_valid), 64'd0);
    chk("reset_out_data", 64'(a_out_data), 64'd0);
    chk("reset_in_ready", 64'(a_in_ready), 64'd1);
    chk("reset_b_out_valid", 64'(b_out_valid), 64'd0);
    @(posedge clk); #1;
    nrst_a = 1'b1; nrst_b = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_in_ready", 64'(a_in_ready), 64'd1);
    chk("post_reset_out_valid", 64'(a_out_valid), 64'd0);

    // Basic jobs, identical latency regardless of input order
    a_start(16'h3A1F, 1'b0); a_wait(16'hFA31); a_take();
    a_start(16'h0123, 1'b0); a_wait(16'h3210); a_take();
    a_start(16'h5555, 1'b0); a_wait(16'h5555); a_take();

    // Backpressure then simultaneous output and input handshakes
    a_start(16'h3A1F, 1'b0); a_wait(16'hFA31); a_hold(3, 16'hFA31);
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_data   = 16'h0123;
    #1;
    chk("a_b2b_in_ready", 64'(a_in_ready), 64'd1);
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    a_in_data   = 16'hFFFF;
    chk("a_b2b_in_sort", 64'(a_out_valid), 64'd0);
    budget = 0;
    while (!a_out_valid && budget < 20) begin @(posedge clk); #1; budget++; end
    a_in_valid = 1'b0;
    chk("a_b2b_latency", 64'(budget), 64'(NA));
    chk("a_b2b_data", 64'(a_out_data), 64'h3210);
    a_take();

    // Reset at phase 2 discards the job
    a_start(16'h3A1F, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    nrst_a = 1'b0;
    #1;
    chk("a_midreset_out_valid", 64'(a_out_valid), 64'd0);
    chk("a_midreset_out_data", 64'(a_out_data), 64'd0);
    chk("a_midreset_in_ready", 64'(a_in_ready), 64'd1);
    a_in_valid = 1'b0;
    @(posedge clk); #1;
    qa.delete();
    nrst_a = 1'b1;
    #1;
    chk("a_release_in_ready", 64'(a_in_ready), 64'd1);
    chk("a_release_out_valid", 64'(a_out_valid), 64'd0);
    @(posedge clk); #1;
    a_start(16'h0123, 1'b0); a_wait(16'h3210); a_take();

`ifdef SORTER_DESC_EN
    a_start(16'h3A1F, 1'b1); a_wait(16'h13AF); a_take();
    a_start(16'h0123, 1'b1); a_wait(16'h0123); a_take();
`endif

    // Random jobs on the N=8, W=8 instance
    b_run = 1'b1;
    for (int j = 0; j < NJOBS; j++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      b_in_data  = {$urandom, $urandom};
      b_desc     = 1'($urandom);
      b_in_valid = 1'b1;
      acc    = 1'b0;
      budget = 0;
      while (!acc && budget < 200) begin
        @(negedge clk);
        acc = b_in_ready;
        @(posedge clk); #1;
        budget++;
      end
      if (!acc) chk("b_accept_timeout", 64'(budget), 64'd0);
      b_in_valid = 1'b0;
    end
    budget = 0;
    while (b_recv < NJOBS && budget < 2000) begin @(posedge clk); #1; budget++; end
    chk("b_job_count", 64'(b_recv), 64'(NJOBS));
    chk("b_queue_empty", 64'(qb.size()), 64'd0);
    chk("a_queue_empty", 64'(qa.size()), 64'd0);
    b_run = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
